// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the write-back arbiter and its long-latency FIFO.
package rv_wb_pkg;

  localparam int         WB_DEPTH_DEFAULT = 4;
  localparam logic [4:0] REG_ZERO         = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/long-latency producers, the decode stage and the arbiter.
interface wb_arbiter_if;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic        stall;
  logic        write_reg;
  logic [4:0]  rd;
  logic [31:0] data_in;
  logic        err;

  modport slave (
    input  pipe_wr_en, pipe_rd, pipe_data,
    input  lr_valid, lr_rd, lr_data,
    input  issue_en, issue_rd,
    input  rs1_q, rs2_q, rd_q,
    output lr_ready, stall, write_reg, rd, data_in, err
  );

  modport master (
    output pipe_wr_en, pipe_rd, pipe_data,
    output lr_valid, lr_rd, lr_data,
    output issue_en, issue_rd,
    output rs1_q, rs2_q, rd_q,
    input  lr_ready, stall, write_reg, rd, data_in, err
  );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries; pointers carry one extra wrap bit so full/empty
// fall out of the pointer difference.
module wb_fifo
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                push_entry,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_ok, pop_ok;
  wb_entry_t   mem_q [DEPTH];

  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    full     = (count == FULL_CNT);
    empty    = (count == '0);
    // full is the pre-pop view, so a simultaneous pop never makes room for a push
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline results win, buffered long-latency results
// fill idle slots, and a busy scoreboard holds decode until pending destinations land.
module wb_arbiter
  import rv_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave wb
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wb_entry_t   fifo_head, fifo_in;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic        push, pop, pipe_real, starve;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;

  always_comb begin
    fifo_in.rd   = wb.lr_rd;
    fifo_in.data = wb.lr_data;
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .push_entry (fifo_in),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_comb begin
    pipe_real = wb.pipe_wr_en && (wb.pipe_rd != REG_ZERO);
    pop       = !reset && !pipe_real && !fifo_empty;
    push      = !reset && wb.lr_valid && !fifo_full;
    starve    = (fifo_count == FULL_CNT);

    wr_en   = 1'b0;
    wr_rd   = REG_ZERO;
    wr_data = '0;
    if (!reset && pipe_real) begin
      wr_en   = 1'b1;
      wr_rd   = wb.pipe_rd;
      wr_data = wb.pipe_data;
    end else if (pop) begin
      // an x0 entry still consumes its slot but never reaches the register file
      wr_en   = (fifo_head.rd != REG_ZERO);
      wr_rd   = fifo_head.rd;
      wr_data = fifo_head.data;
    end

    busy_d = busy_q;
    err_d  = err_q;
    if (pop && fifo_head.rd != REG_ZERO) begin
      if (!busy_q[fifo_head.rd]) err_d = 1'b1;
      busy_d[fifo_head.rd] = 1'b0;
    end
    // applied after the clear so a same-edge issue keeps the register busy
    if (wb.issue_en && wb.issue_rd != REG_ZERO) begin
      if (busy_q[wb.issue_rd]) err_d = 1'b1;
      busy_d[wb.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign wb.lr_ready  = !reset && !fifo_full;
  assign wb.stall     = !reset && (busy_q[wb.rs1_q] || busy_q[wb.rs2_q] || busy_q[wb.rd_q] || starve);
  assign wb.write_reg = wr_en;
  assign wb.rd        = wr_rd;
  assign wb.data_in   = wr_data;
  assign wb.err       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed scenarios plus a random phase against a queue model.
module tb_wb_arbiter;
  import rv_wb_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    bit ready;
    bit stall;
    bit err;
  } exp_stat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if wb();

  wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;
  wb_entry_t   exp_wr[$];
  exp_stat_t   exp_st[$];
  wb_entry_t   m_fifo[$];
  bit [31:0]   m_busy = '0;
  bit          m_err  = 1'b0;
  logic [4:0]  pending[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    return m_busy[wb.rs1_q] | m_busy[wb.rs2_q] | m_busy[wb.rd_q] | (m_fifo.size() == DEPTH);
  endfunction

  // Reference model: computes this cycle's expected outputs, then advances to the next edge.
  task automatic cycle();
    exp_stat_t s;
    wb_entry_t e;
    bit        real_wr, ready, pop;
    bit [31:0] nb;
    ready   = (m_fifo.size() < DEPTH);
    s.ready = ready;
    s.stall = m_stall();
    s.err   = m_err;
    exp_st.push_back(s);
    real_wr = wb.pipe_wr_en && (wb.pipe_rd != 5'd0);
    pop     = !real_wr && (m_fifo.size() > 0);
    nb      = m_busy;
    if (real_wr) begin
      e.rd = wb.pipe_rd;
      e.data = wb.pipe_data;
      exp_wr.push_back(e);
    end else if (pop) begin
      e = m_fifo.pop_front();
      if (e.rd != 5'd0) begin
        exp_wr.push_back(e);
        if (!m_busy[e.rd]) m_err = 1'b1;
        nb[e.rd] = 1'b0;
      end
    end
    if (wb.issue_en && wb.issue_rd != 5'd0) begin
      if (m_busy[wb.issue_rd]) m_err = 1'b1;
      nb[wb.issue_rd] = 1'b1;
    end
    m_busy = nb;
    if (wb.lr_valid && ready) begin
      e.rd = wb.lr_rd;
      e.data = wb.lr_data;
      m_fifo.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb.pipe_wr_en = 1'b0; wb.pipe_rd = '0; wb.pipe_data = '0;
    wb.lr_valid = 1'b0; wb.lr_rd = '0; wb.lr_data = '0;
    wb.issue_en = 1'b0; wb.issue_rd = '0;
    wb.rs1_q = '0; wb.rs2_q = '0; wb.rd_q = '0;
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur (got none, required one)", name);
  endtask

  // Monitor: status every cycle, write contents whenever the port is enabled.
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      if (exp_st.size() == 0) begin
        fail_now("stat_queue");
      end else begin
        exp_stat_t s;
        s = exp_st.pop_front();
        check("lr_ready", wb.lr_ready, s.ready);
        check("stall", wb.stall, s.stall);
        check("err", wb.err, s.err);
      end
      if (wb.write_reg) begin
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h, required no write", wb.rd, wb.data_in);
        end else begin
          wb_entry_t e;
          e = exp_wr.pop_front();
          check("wr_rd", wb.rd, e.rd);
          check("wr_data", wb.data_in, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int guard;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", wb.lr_ready, 1'b0);
    check("wr_in_reset", wb.write_reg, 1'b0);
    reset = 1'b0;
    #1;
    check("idle_write_reg", wb.write_reg, 1'b0);
    check("idle_lr_ready", wb.lr_ready, 1'b1);
    check("idle_stall", wb.stall, 1'b0);
    check("idle_err", wb.err, 1'b0);
    check("idle_rd", wb.rd, 5'd0);
    check("idle_data", wb.data_in, 32'd0);
    chk_en = 1'b1;
    repeat (3) cycle();

    // single long-latency result to x5
    wb.issue_en = 1'b1; wb.issue_rd = 5'd5;
    cycle();
    wb.issue_en = 1'b0;
    wb.rs1_q = 5'd5;
    wb.lr_valid = 1'b1; wb.lr_rd = 5'd5; wb.lr_data = 32'hDEADBEEF;
    #1 check("stall_busy5", wb.stall, 1'b1);
    cycle();
    wb.lr_valid = 1'b0;
    #1;
    check("x5_write_en", wb.write_reg, 1'b1);
    check("x5_write_rd", wb.rd, 5'd5);
    check("x5_write_data", wb.data_in, 32'hDEADBEEF);
    check("x5_stall_until_write", wb.stall, 1'b1);
    cycle();
    check("busy5_cleared", wb.stall, 1'b0);
    wb.rs1_q = 5'd0;
    cycle();

    // FIFO fill under continuous pipeline writes, then starve-driven drain
    for (int r = 8; r <= 11; r++) begin
      wb.issue_en = 1'b1; wb.issue_rd = 5'(r);
      wb.pipe_wr_en = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = $urandom;
      cycle();
    end
    wb.issue_en = 1'b0;
    idx = 0;
    for (int step = 0; step < 12; step++) begin
      wb.pipe_wr_en = !m_stall(); wb.pipe_rd = 5'd3; wb.pipe_data = $urandom;
      wb.lr_valid = (idx < 4);
      wb.lr_rd = 5'(8 + idx); wb.lr_data = 32'hA000_0000 + 32'(idx);
      if (idx == 4 && step == 4) begin
        check("full_lr_ready", wb.lr_ready, 1'b0);
        check("full_starve", wb.stall, 1'b1);
      end
      if (wb.lr_valid && m_fifo.size() < DEPTH) idx++;
      cycle();
    end
    idle_inputs();
    guard = 0;
    while (m_fifo.size() > 0 && guard < DEPTH + 4) begin
      cycle();
      guard++;
    end
    if (m_fifo.size() > 0) fail_now("drain_bound");
    cycle();
    check("drain_all_written", exp_wr.size(), 0);

    // x0 pipeline request leaves the slot to the FIFO
    wb.issue_en = 1'b1; wb.issue_rd = 5'd7;
    cycle();
    wb.issue_en = 1'b0;
    wb.pipe_wr_en = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = 32'h1234_5678;
    wb.lr_valid = 1'b1; wb.lr_rd = 5'd7; wb.lr_data = 32'h0000_0777;
    cycle();
    wb.lr_valid = 1'b0;
    wb.pipe_rd = 5'd0;
    #1;
    check("x0_slot_write_en", wb.write_reg, 1'b1);
    check("x0_slot_rd", wb.rd, 5'd7);
    cycle();
    idle_inputs();
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] r, iss;
      bit acc;
      wb.rs1_q = 5'($urandom_range(0, 31));
      wb.rs2_q = 5'($urandom_range(0, 31));
      wb.rd_q  = 5'($urandom_range(0, 31));
      wb.pipe_wr_en = ($urandom_range(0, 1) == 1) && !m_stall();
      wb.pipe_rd = 5'($urandom_range(0, 31));
      wb.pipe_data = $urandom;
      r = 5'($urandom_range(1, 31));
      wb.issue_en = ($urandom_range(0, 3) == 0) && !m_busy[r];
      wb.issue_rd = r;
      wb.lr_valid = 1'b0; wb.lr_rd = '0;
      if (pending.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb.lr_valid = 1'b1; wb.lr_rd = pending[0];
      end else if ($urandom_range(0, 9) == 0) begin
        wb.lr_valid = 1'b1; wb.lr_rd = 5'd0;
      end
      wb.lr_data = $urandom;
      acc = wb.lr_valid && (m_fifo.size() < DEPTH);
      iss = wb.issue_en ? wb.issue_rd : 5'd0;
      cycle();
      if (acc && wb.lr_rd != 5'd0) void'(pending.pop_front());
      if (iss != 5'd0) pending.push_back(iss);
    end
    idle_inputs();
    guard = 0;
    while ((pending.size() > 0 || m_fifo.size() > 0) && guard < 200) begin
      wb.lr_valid = (pending.size() > 0);
      wb.lr_rd = (pending.size() > 0) ? pending[0] : 5'd0;
      wb.lr_data = $urandom;
      if (wb.lr_valid && m_fifo.size() < DEPTH) begin
        cycle();
        void'(pending.pop_front());
      end else begin
        cycle();
      end
      guard++;
    end
    if (pending.size() > 0 || m_fifo.size() > 0) fail_now("random_drain_bound");
    idle_inputs();
    cycle();
    check("random_all_written", exp_wr.size(), 0);
    check("random_no_err", wb.err, 1'b0);

    // double issue raises sticky err; issue on pop edge keeps busy
    wb.issue_en = 1'b1; wb.issue_rd = 5'd9;
    cycle();
    cycle();
    wb.issue_en = 1'b0;
    #1 check("err_double_issue", wb.err, 1'b1);
    wb.lr_valid = 1'b1; wb.lr_rd = 5'd9; wb.lr_data = 32'h0000_0009;
    cycle();
    wb.lr_valid = 1'b0;
    wb.issue_en = 1'b1; wb.issue_rd = 5'd9;
    cycle();
    wb.issue_en = 1'b0;
    wb.rs1_q = 5'd9;
    #1 check("busy9_kept", wb.stall, 1'b1);
    cycle();
    cycle();
    check("err_sticky", wb.err, 1'b1);
    check("busy9_still", wb.stall, 1'b1);

    // async reset with queued entries and a pending destination
    wb.rs1_q = 5'd0;
    cycle();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_st.delete(); exp_wr.delete(); m_fifo.delete();
    m_busy = '0; m_err = 1'b0;
    wb.issue_en = 1'b1; wb.issue_rd = 5'd4;
    cycle();
    wb.issue_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wb.pipe_wr_en = 1'b1; wb.pipe_rd = 5'd3; wb.pipe_data = $urandom;
      wb.lr_valid = 1'b1; wb.lr_rd = 5'(4 + 16 * k); wb.lr_data = $urandom;
      cycle();
    end
    wb.lr_valid = 1'b0;
    wb.rs1_q = 5'd4;
    #1 check("pre_reset_busy4", wb.stall, 1'b1);
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_write_reg", wb.write_reg, 1'b0);
    check("rst_lr_ready", wb.lr_ready, 1'b0);
    check("rst_stall", wb.stall, 1'b0);
    check("rst_err", wb.err, 1'b0);
    exp_st.delete(); exp_wr.delete(); m_fifo.delete();
    m_busy = '0; m_err = 1'b0;
    wb.pipe_wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("post_rst_busy4", wb.stall, 1'b0);
    check("post_rst_empty", wb.write_reg, 1'b0);
    check("post_rst_ready", wb.lr_ready, 1'b1);
    chk_en = 1'b1;
    repeat (3) cycle();
    check("final_all_written", exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
